// File: rtl/serial_tx_arbiter.sv
// Packet-granular round-robin share of one serial_tx between two byte requesters.
// Transfer-to-tx_dv is 1 clock; ready is held low while a byte is in flight or another owner holds the grant.
module serial_tx_arbiter #(
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_byte,
  output logic       tx_dv,
  input  logic       tx_done,
  output logic       busy,
  output logic       owner,
  output logic       timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, GAP, HOLD} state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic [7:0]      gap_cnt;
  logic            last_flag;
  logic            rr;
  logic            pick, sel, grant_ok, sel_valid, sel_last, xfer;
  logic [7:0]      sel_data;
  logic            wd_term, gap_term;
  state_t          rel_state;

  always_comb begin
    // rr names the requester favoured when both ask at once
    pick = rr;
    if (req0_valid && !req1_valid)
      pick = 1'b0;
    else if (req1_valid && !req0_valid)
      pick = 1'b1;

    sel       = (state == IDLE) ? pick : owner;
    grant_ok  = ((state == IDLE) && (req0_valid || req1_valid)) || (state == HOLD);
    sel_valid = sel ? req1_valid : req0_valid;
    sel_data  = sel ? req1_data  : req0_data;
    sel_last  = sel ? req1_last  : req0_last;
    xfer      = grant_ok && sel_valid;

    req0_ready = grant_ok && !sel;
    req1_ready = grant_ok && sel;

    wd_term   = (wd_cnt == WD_LAST);
    gap_term  = (gap_cnt == GAP_LAST);
    rel_state = last_flag ? IDLE : HOLD;
  end

  always_comb begin
    state_nxt   = state;
    tx_dv       = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: if (xfer) state_nxt = SEND;
      SEND: begin
        tx_dv     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done on the terminal-count cycle still counts as a normal completion
        if (tx_done)
          state_nxt = (GAP_CYCLES > 0) ? GAP : rel_state;
        else if (wd_term) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      GAP:  if (gap_term) state_nxt = rel_state;
      HOLD: if (xfer) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx_byte   <= 8'h00;
      owner     <= 1'b0;
      rr        <= 1'b0;
      wd_cnt    <= '0;
      gap_cnt   <= 8'd0;
      last_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        tx_byte   <= sel_data;
        last_flag <= sel_last;
        owner     <= sel;
      end
      // every exit to IDLE (packet end or abort) hands priority to the other side
      if ((state != IDLE) && (state_nxt == IDLE))
        rr <= ~owner;
      case (state)
        SEND: wd_cnt <= '0;
        WAIT: begin
          if (!wd_term) wd_cnt <= wd_cnt + WD_W'(1);
          gap_cnt <= 8'd0;
        end
        GAP:  if (!gap_term) gap_cnt <= gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with a byte scoreboard and a simple serial_tx done model.
module tb_serial_tx_arbiter;

  localparam int GAP      = 10;
  localparam int TIMEOUT  = 100;
  localparam int DONE_DLY = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_byte;
  logic       tx_dv, busy, owner, timeout_err;
  logic       tx_done;
  logic       model_done = 1'b0, stale_done = 1'b0, hold_done = 1'b0;

  int tests = 0;
  int fails = 0;
  int lock_viol = 0;
  logic [7:0] sb[$];
  logic [7:0] dv_log[$];
  logic       own_log[$];

  assign tx_done = model_done | stale_done;

  serial_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_byte(tx_byte), .tx_dv(tx_dv), .tx_done(tx_done),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    stale_done = 1'b1;
    tick();
    stale_done = 1'b0;
  endtask

  // Presents one byte and returns just after the clock edge that transferred it.
  task automatic xfer(input bit n, input logic [7:0] d, input logic l);
    int k;
    if (n) begin req1_data = d; req1_last = l; req1_valid = 1'b1; end
    else   begin req0_data = d; req0_last = l; req0_valid = 1'b1; end
    #1;
    k = 0;
    while (!(n ? req1_ready : req0_ready) && k < 400) begin
      if (!n && req1_valid && req1_ready) lock_viol++;
      tick();
      k++;
    end
    chk("xfer_wait_bound", 32'(k < 400), 32'd1);
    tick();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 500) begin
      tick();
      k++;
    end
    chk("idle_wait_bound", 32'(busy), 32'd0);
  endtask

  // serial_tx stand-in: done a fixed delay after each tx_dv unless suppressed
  always begin
    @(negedge clk);
    if (tx_dv && !hold_done) begin
      repeat (DONE_DLY) @(posedge clk);
      #1 model_done = 1'b1;
      @(posedge clk);
      #1 model_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (req0_valid && req0_ready) sb.push_back(req0_data);
      if (req1_valid && req1_ready) sb.push_back(req1_data);
      if (tx_dv) begin
        dv_log.push_back(tx_byte);
        own_log.push_back(owner);
        if (sb.size() == 0)
          chk("sb_underflow", 32'(tx_byte), 32'hFFFF_FFFF);
        else
          chk("sb_byte", 32'(tx_byte), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int k;

    // reset values
    repeat (2) tick();
    chk("rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);

    // round-robin: both valid after reset, req0 first, then alternate
    dv_log.delete(); own_log.delete();
    req0_data = 8'h10; req0_last = 1'b1; req0_valid = 1'b1;
    req1_data = 8'h20; req1_last = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rr_first_ready0", 32'(req0_ready), 32'd1);
    chk("rr_first_ready1", 32'(req1_ready), 32'd0);
    k = 0;
    while (dv_log.size() < 4 && k < 600) begin tick(); k++; end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", 32'(own_log.size()), 32'd4);
    chk("rr_owner0", 32'(own_log[0]), 32'd0);
    chk("rr_owner1", 32'(own_log[1]), 32'd1);
    chk("rr_owner2", 32'(own_log[2]), 32'd0);
    chk("rr_owner3", 32'(own_log[3]), 32'd1);
    wait_idle();

    // single byte, done driven by hand to time the gap
    hold_done = 1'b1;
    req0_data = 8'h41; req0_last = 1'b1; req0_valid = 1'b1;
    #1;
    chk("single_ready_same_cycle", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("single_tx_dv", 32'(tx_dv), 32'd1);
    chk("single_tx_byte", 32'(tx_byte), 32'h41);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    chk("single_dv_one_cycle", 32'(tx_dv), 32'd0);
    repeat (5) tick();
    pulse_done();
    repeat (9) tick();
    chk("single_gap_busy", 32'(busy), 32'd1);
    tick();
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_byte_held", 32'(tx_byte), 32'h41);

    // two-byte packet through the gap
    req1_data = 8'hA1; req1_last = 1'b0; req1_valid = 1'b1;
    #1;
    tick();
    chk("gap_first_dv", 32'(tx_dv), 32'd1);
    req1_data = 8'hA2; req1_last = 1'b1;
    repeat (3) tick();
    pulse_done();
    repeat (9) tick();
    chk("gap_ready_early", 32'(req1_ready), 32'd0);
    tick();
    chk("gap_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("gap_second_dv", 32'(tx_dv), 32'd1);
    chk("gap_second_byte", 32'(tx_byte), 32'hA2);
    chk("gap_owner", 32'(owner), 32'd1);
    repeat (3) tick();
    pulse_done();
    wait_idle();

    // packet lock: req1 waits behind req0's three-byte packet
    hold_done = 1'b0;
    dv_log.delete(); lock_viol = 0;
    req1_data = 8'h55; req1_last = 1'b1; req1_valid = 1'b1;
    xfer(1'b0, 8'h41, 1'b0);
    xfer(1'b0, 8'h42, 1'b0);
    xfer(1'b0, 8'h43, 1'b1);
    req0_valid = 1'b0;
    xfer(1'b1, 8'h55, 1'b1);
    req1_valid = 1'b0;
    chk("lock_owner", 32'(owner), 32'd1);
    wait_idle();
    chk("lock_req1_ready_leak", 32'(lock_viol), 32'd0);
    chk("lock_count", 32'(dv_log.size()), 32'd4);
    chk("lock_order0", 32'(dv_log[0]), 32'h41);
    chk("lock_order1", 32'(dv_log[1]), 32'h42);
    chk("lock_order2", 32'(dv_log[2]), 32'h43);
    chk("lock_order3", 32'(dv_log[3]), 32'h55);

    // watchdog: done withheld, 100 WAIT clocks then abort
    hold_done = 1'b1;
    xfer(1'b0, 8'h77, 1'b1);
    req0_valid = 1'b0;
    chk("wd_tx_dv", 32'(tx_dv), 32'd1);
    k = 0;
    while (!timeout_err && k < 300) begin tick(); k++; end
    chk("wd_latency", 32'(k), 32'(TIMEOUT));
    tick();
    chk("wd_idle", 32'(busy), 32'd0);
    chk("wd_single_pulse", 32'(timeout_err), 32'd0);
    pulse_done();
    chk("wd_stale_done_busy", 32'(busy), 32'd0);
    chk("wd_stale_done_dv", 32'(tx_dv), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("wd_rr_flip_ready1", 32'(req1_ready), 32'd1);
    chk("wd_rr_flip_ready0", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // reset in the middle of WAIT
    tick();
    xfer(1'b1, 8'h99, 1'b1);
    req1_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    pulse_done();
    chk("mid_rst_stale_done", 32'(busy), 32'd0);
    hold_done = 1'b0;
    xfer(1'b1, 8'hAA, 1'b1);
    req1_valid = 1'b0;
    chk("post_rst_tx_dv", 32'(tx_dv), 32'd1);
    chk("post_rst_owner", 32'(owner), 32'd1);
    wait_idle();
    repeat (2) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares the single serial_tx transmitter between two byte-stream requesters.
- Requester 0 is the serial_msg_receiver echo/forward path. Requester 1 is a status/ack generator.
- Round-robin arbitration at packet granularity: once granted, a requester keeps the transmitter until it sends a byte marked last.
- Sequences each byte as one tx_dv pulse, then waits for tx_done, with an optional inter-byte gap and a lost-done watchdog.

Parameters:
GAP_CYCLES, 0, idle clocks inserted after each tx_done before the next byte may be accepted (0..255).
TIMEOUT_CYCLES, 8192, clocks allowed in WAIT without tx_done before abort. One 115200-baud frame at 48 MHz is about 4167 clocks.

Ports:
clk  input  1  system clock (48 MHz SB_HFOSC)
reset  input  1  synchronous, active-high reset
req0_data  input  8  requester 0 byte
req0_valid  input  1  requester 0 byte available
req0_last  input  1  requester 0 byte ends packet; releases grant after it is sent
req0_ready  output  1  requester 0 byte accepted this cycle (valid&ready = transfer)
req1_data  input  8  requester 1 byte
req1_valid  input  1  requester 1 byte available
req1_last  input  1  requester 1 end of packet
req1_ready  output  1  requester 1 byte accepted this cycle
tx_byte  output  8  to serial_tx i_Tx_Byte
tx_dv  output  1  to serial_tx i_Tx_DV, single-cycle pulse
tx_done  input  1  from serial_tx o_Tx_Done, single-cycle pulse
busy  output  1  high in any state other than IDLE
owner  output  1  index of current or last grant holder
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: state IDLE, tx_byte 8'h00, tx_dv 0, busy 0, owner 0, timeout_err 0, rr pointer favours req0, counters 0, last_flag 0.
- States: IDLE, SEND, WAIT, GAP, HOLD.
- reqN_ready is combinational:
  - In IDLE: high for the picked requester only.
  - In HOLD: high only when N == owner.
  - All other states: 0.
- IDLE pick:
  - If exactly one reqN_valid is set, pick N.
  - If both are set, pick the requester not granted most recently (rr pointer).
  - On transfer: register tx_byte <= data, last_flag <= last, owner <= N, go to SEND.
- SEND: lasts exactly one cycle with tx_dv = 1, then WAIT; clears the watchdog counter. Transfer-to-tx_dv latency is 1 clock.
- WAIT:
  - Counter increments each cycle.
  - On tx_done: go to GAP if GAP_CYCLES > 0, else evaluate release immediately.
  - If the counter reaches TIMEOUT_CYCLES-1 without tx_done: pulse timeout_err, drop the grant, flip rr, go to IDLE. The rest of the packet is not forced; the requester re-arbitrates.
- GAP: counts GAP_CYCLES clocks, then evaluates release.
- Release evaluation:
  - last_flag = 1: go to IDLE, rr pointer now favours the other requester.
  - Otherwise: go to HOLD.
- HOLD:
  - Waits indefinitely for owner's valid; transfer goes to SEND.
  - The non-owner's valid is ignored; its ready stays 0.
- tx_done in IDLE, SEND, GAP or HOLD is ignored. This covers stale done after a reset or timeout.
- Simultaneous tx_done and timeout terminal count in WAIT: tx_done wins, no timeout_err.
- Simultaneous valid on both requesters in HOLD: only owner is served.
- tx_byte holds its value between loads; it changes only on a transfer.
- Reset mid-operation: everything returns to reset values next clock. A frame already in serial_tx completes on its own; its tx_done is ignored.
- Counter widths: watchdog counter is $clog2(TIMEOUT_CYCLES)+1 bits; gap counter is 8 bits. Neither wraps.

Test Plan:
- Single byte: req0 valid with 8'h41, last=1, in IDLE -> req0_ready high the same cycle; tx_byte=8'h41 and tx_dv=1 the next cycle; tx_done 4167 clocks later -> IDLE, busy=0.
- Packet lock: req0 sends 8'h41,8'h42,8'h43 (last on 8'h43) while req1 holds valid with 8'h55 -> tx_dv order 41,42,43,55; req1_ready stays 0 until after 43's tx_done.
- Round-robin: both valid in IDLE after reset -> req0 granted first; both re-present single-byte packets repeatedly -> owner alternates 0,1,0,1.
- Gap: GAP_CYCLES=10, two-byte packet -> exactly 10 clocks from first tx_done to second byte's ready; tx_dv pulses 11 clocks apart after done.
- Watchdog: TIMEOUT_CYCLES=100, tx_done withheld -> timeout_err one pulse at cycle 100 after SEND, state IDLE; a stale tx_done afterwards causes no state change.
- Reset mid-WAIT: assert reset for 1 clock during WAIT -> tx_dv=0, busy=0, owner=0 next clock; the subsequent tx_done is ignored; the next req1 packet is served normally.
